// File: rtl/img_mem_seq_if.sv
// Signal bundle between the control block, the image-memory sequencer and its consumers.
// The master side drives the control levels; the slave side is the sequencer.
interface img_mem_seq_if #(
    parameter int ADDR_W = 12
);
    logic              i_valid;
    logic              i_load;
    logic              i_run;
    logic [9:0]        i_imgLength;
    logic              o_we;
    logic [ADDR_W-1:0] o_wr_addr;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic              o_col_start;
    logic              o_EOP;
    logic [ADDR_W:0]   o_pix_count;
    logic              o_ovf;
    logic [2:0]        o_state;

    modport master (
        output i_valid, i_load, i_run, i_imgLength,
        input  o_we, o_wr_addr, o_rd_en, o_rd_addr, o_col_start,
        input  o_EOP, o_pix_count, o_ovf, o_state
    );

    modport slave (
        input  i_valid, i_load, i_run, i_imgLength,
        output o_we, o_wr_addr, o_rd_en, o_rd_addr, o_col_start,
        output o_EOP, o_pix_count, o_ovf, o_state
    );
endinterface

// File: rtl/img_mem_seq.sv
// Image-memory sequencer: writes incoming pixels into the image BRAM during load,
// then streams read addresses with column-start markers to the convolution datapath.
module img_mem_seq #(
    parameter int ADDR_W    = 12,
    parameter int FLUSH_LAT = 3
) (
    input logic          i_CLK,
    input logic          i_rst,
    img_mem_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_LAT - 1);

    state_t            state;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              col_start;
    logic              eop;
    logic [ADDR_W:0]   pix_count;
    logic              ovf;
    logic [ADDR_W:0]   rd_cnt;
    logic [9:0]        col_cnt;
    logic [9:0]        img_len;
    logic [3:0]        flush_cnt;

    // A zero column length never wraps, so only the very first read is marked.
    function automatic logic [9:0] col_next(input logic [9:0] cnt, input logic [9:0] len);
        if (len != 10'd0 && cnt == len - 10'd1)
            return 10'd0;
        return cnt + 10'd1;
    endfunction

    function automatic logic col_first(input logic [9:0] cnt, input logic [9:0] len,
                                       input logic first);
        return first || (len != 10'd0 && cnt == 10'd0);
    endfunction

    always_ff @(posedge i_CLK) begin
        if (!i_rst) begin
            state     <= IDLE;
            we        <= 1'b0;
            wr_addr   <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            col_start <= 1'b0;
            eop       <= 1'b0;
            pix_count <= '0;
            ovf       <= 1'b0;
            rd_cnt    <= '0;
            col_cnt   <= '0;
            img_len   <= '0;
            flush_cnt <= '0;
        end else begin
            we        <= 1'b0;
            rd_en     <= 1'b0;
            col_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_load) begin
                        state     <= LOAD;
                        pix_count <= '0;
                        wr_addr   <= '0;
                        ovf       <= 1'b0;
                    end else if (bus.i_run) begin
                        state   <= RUN;
                        rd_cnt  <= '0;
                        rd_addr <= '0;
                        col_cnt <= '0;
                        img_len <= bus.i_imgLength;
                    end
                end
                LOAD: begin
                    if (bus.i_run) begin
                        state   <= RUN;
                        rd_cnt  <= '0;
                        rd_addr <= '0;
                        col_cnt <= '0;
                        img_len <= bus.i_imgLength;
                    end else begin
                        if (!bus.i_load)
                            state <= IDLE;
                        // The top bit of pix_count set means the memory is full.
                        if (bus.i_valid) begin
                            if (!pix_count[ADDR_W]) begin
                                we        <= 1'b1;
                                wr_addr   <= pix_count[ADDR_W-1:0];
                                pix_count <= pix_count + 1'b1;
                            end else begin
                                ovf <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    if (!bus.i_run) begin
                        state <= IDLE;
                    end else if (rd_cnt == pix_count) begin
                        // An empty image skips the drain wait entirely.
                        if (pix_count == '0) begin
                            state <= DONE;
                            eop   <= 1'b1;
                        end else begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end
                    end else begin
                        rd_en     <= 1'b1;
                        rd_addr   <= rd_cnt[ADDR_W-1:0];
                        col_start <= col_first(col_cnt, img_len, rd_cnt == '0);
                        col_cnt   <= col_next(col_cnt, img_len);
                        rd_cnt    <= rd_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (!bus.i_run) begin
                        state <= IDLE;
                    end else if (flush_cnt == FLUSH_LAST) begin
                        state <= DONE;
                        eop   <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (!bus.i_run) begin
                        state <= IDLE;
                        eop   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    eop   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_we        = we;
    assign bus.o_wr_addr   = wr_addr;
    assign bus.o_rd_en     = rd_en;
    assign bus.o_rd_addr   = rd_addr;
    assign bus.o_col_start = col_start;
    assign bus.o_EOP       = eop;
    assign bus.o_pix_count = pix_count;
    assign bus.o_ovf       = ovf;
    assign bus.o_state     = state;

endmodule
